button_debounce: RTL and testbench

BUTTON_DEBOUNCE -- requirements
Module: button_debounce

---
 rtl/button_debounce.sv | 185 ++++++++++++++++++
 tb/tb_button_debounce.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/button_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
//
// Debounces eight decoded controller buttons and derives edge pulses plus
// auto-repeat events for the four direction buttons.
//
// Ports:
//   clk          system clock; all logic is clocked on the rising edge
//   rst          synchronous active-high reset
//   btn_raw      [7:0] raw buttons, asynchronous to clk (1 = pressed)
//                bit0 A, bit1 B, bit2 Select, bit3 Start,
//                bit4 Right, bit5 Left, bit6 Up, bit7 Down
//   repeat_en    enables auto-repeat on the direction bits (4..7)
//   btn_level    [7:0] debounced pressed level
//   btn_press    [7:0] one-cycle pulse on a debounced 0->1 transition
//   btn_release  [7:0] one-cycle pulse on a debounced 1->0 transition
//   btn_event    [7:0] btn_press OR auto-repeat pulse (bits 4..7 only)
//   any_press    OR-reduction of btn_press
// -----------------------------------------------------------------------------
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] btn_raw,
  input  logic       repeat_en,
  output logic [7:0] btn_level,
  output logic [7:0] btn_press,
  output logic [7:0] btn_release,
  output logic [7:0] btn_event,
  output logic       any_press
);

  localparam int unsigned CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned TW   = $clog2(TMAX + 1);

  localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] DELAY_LAST = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] PERIOD_LAST = TW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_REPEAT
  } rep_state_e;

  // Two-flop synchronizer; sync_q is the clean, clk-domain view of btn_raw.
  logic [7:0] meta_q;
  logic [7:0] sync_q;

  logic [7:0] level_q, level_d;
  logic [7:0] press_q, release_q;
  logic [3:0] rep_pulse;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q    <= '0;
      sync_q    <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
    end else begin
      meta_q    <= btn_raw;
      sync_q    <= meta_q;
      level_q   <= level_d;
      // Pulses are registered alongside the level so they are high exactly
      // in the first cycle btn_level shows the new value.
      press_q   <= level_d & ~level_q;
      release_q <= ~level_d & level_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-bit debounce counters
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_deb
      logic [CW-1:0] cnt_q, cnt_d;
      logic          lvl_d;

      always_comb begin
        cnt_d = '0;
        lvl_d = level_q[gi];
        if (sync_q[gi] != level_q[gi]) begin
          if (cnt_q == CNT_LAST) begin
            // Input has disagreed for DEBOUNCE_CYCLES consecutive cycles.
            lvl_d = sync_q[gi];
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign level_d[gi] = lvl_d;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Auto-repeat FSMs for direction bits 4..7
  // ---------------------------------------------------------------------------
  generate
    for (gi = 4; gi < 8; gi++) begin : g_rep
      rep_state_e    state_q, state_d;
      logic [TW-1:0] timer_q, timer_d;
      logic          pulse_q, pulse_d;

      always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        pulse_d = 1'b0;
        // Looking at the next level means a release takes effect on the same
        // edge btn_level falls, so no repeat can ever accompany a release.
        if (!(level_d[gi] && repeat_en)) begin
          state_d = ST_IDLE;
          timer_d = '0;
        end else begin
          case (state_q)
            ST_IDLE: begin
              // Only a fresh press arms the repeat; enabling repeat while a
              // direction is already held does nothing.
              if (press_q[gi]) begin
                state_d = ST_DELAY;
                timer_d = '0;
              end
            end
            ST_DELAY: begin
              if (timer_q == DELAY_LAST) begin
                state_d = ST_REPEAT;
                timer_d = '0;
                pulse_d = 1'b1;
              end else begin
                timer_d = timer_q + TW'(1);
              end
            end
            ST_REPEAT: begin
              if (timer_q == PERIOD_LAST) begin
                timer_d = '0;
                pulse_d = 1'b1;
              end else begin
                timer_d = timer_q + TW'(1);
              end
            end
            default: begin
              state_d = ST_IDLE;
              timer_d = '0;
            end
          endcase
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          state_q <= ST_IDLE;
          timer_q <= '0;
          pulse_q <= 1'b0;
        end else begin
          state_q <= state_d;
          timer_q <= timer_d;
          pulse_q <= pulse_d;
        end
      end

      assign rep_pulse[gi-4] = pulse_q;
    end
  endgenerate

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_event   = press_q | {rep_pulse, 4'b0000};
  assign any_press   = |press_q;

endmodule

// File: tb/tb_button_debounce.sv
// -----------------------------------------------------------------------------
// tb_button_debounce
//
// Directed bench for button_debounce with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10,
// REPEAT_PERIOD=3. Stimulus pushes the expected pulse cycles into a queue; a
// monitor pops and compares whenever the DUT shows any pulse.
// -----------------------------------------------------------------------------
module tb_button_debounce;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] btn_raw;
  logic       repeat_en;
  logic [7:0] btn_level, btn_press, btn_release, btn_event;
  logic       any_press;

  button_debounce #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .repeat_en  (repeat_en),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_event  (btn_event),
    .any_press  (any_press)
  );

  always #5 clk = ~clk;

  // Number of rising edges so far; read on the falling edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [7:0] lvl;
    logic [7:0] prs;
    logic [7:0] rel;
    logic [7:0] evt;
    logic       anyp;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic push(input int c, input logic [7:0] lvl, input logic [7:0] prs,
                      input logic [7:0] rel, input logic [7:0] evt);
    exp_t e;
    e.cyc  = c;
    e.lvl  = lvl;
    e.prs  = prs;
    e.rel  = rel;
    e.evt  = evt;
    e.anyp = |prs;
    exp_q.push_back(e);
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_quiet(input string name, input logic [7:0] lvl_exp);
    tests++;
    if (btn_level !== lvl_exp || btn_press !== 8'h00 || btn_release !== 8'h00 ||
        btn_event !== 8'h00 || any_press !== 1'b0) begin
      fails++;
      $display("FAIL %s: cyc=%0d lvl=%h prs=%h rel=%h evt=%h any=%b, required lvl=%h and no pulses",
               name, cyc, btn_level, btn_press, btn_release, btn_event, any_press, lvl_exp);
    end else begin
      $display("[TB] %s ok at cyc=%0d lvl=%h", name, cyc, btn_level);
    end
  endtask

  // Monitor: any pulse on the outputs is one transaction.
  always @(negedge clk) begin
    if ((btn_press | btn_release | btn_event) != 8'h00) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pulse: cyc=%0d lvl=%h prs=%h rel=%h evt=%h any=%b, required no pulse",
                 cyc, btn_level, btn_press, btn_release, btn_event, any_press);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (cyc != e.cyc || btn_level !== e.lvl || btn_press !== e.prs ||
            btn_release !== e.rel || btn_event !== e.evt || any_press !== e.anyp) begin
          fails++;
          $display("FAIL pulse: got cyc=%0d lvl=%h prs=%h rel=%h evt=%h any=%b, required cyc=%0d lvl=%h prs=%h rel=%h evt=%h any=%b",
                   cyc, btn_level, btn_press, btn_release, btn_event, any_press,
                   e.cyc, e.lvl, e.prs, e.rel, e.evt, e.anyp);
        end else begin
          $display("[TB] pulse cyc=%0d lvl=%h prs=%h rel=%h evt=%h any=%b",
                   cyc, btn_level, btn_press, btn_release, btn_event, any_press);
        end
      end
    end
  end

  initial begin
    int t;
    int r;
    int r2;
    rst       = 1'b1;
    btn_raw   = 8'h00;
    repeat_en = 1'b0;
    wait_neg(3);
    check_quiet("reset_state", 8'h00);
    rst = 1'b0;
    wait_neg(2);

    // A: press and release with exact 6-edge latency.
    t = cyc; btn_raw = 8'h01;
    push(t + 6, 8'h01, 8'h01, 8'h00, 8'h01);
    wait_neg(12);
    check_quiet("a_held_level", 8'h01);
    t = cyc; btn_raw = 8'h00;
    push(t + 6, 8'h00, 8'h00, 8'h01, 8'h00);
    wait_neg(12);

    // B: 3-cycle glitch is rejected.
    btn_raw = 8'h02;
    wait_neg(3);
    btn_raw = 8'h00;
    wait_neg(10);
    check_quiet("glitch_rejected", 8'h00);

    // Right held 30 cycles with repeat enabled.
    repeat_en = 1'b1;
    t = cyc; btn_raw = 8'h10;
    push(t + 6, 8'h10, 8'h10, 8'h00, 8'h10);
    for (int k = 0; k < 7; k++) push(t + 17 + 3 * k, 8'h10, 8'h00, 8'h00, 8'h10);
    wait_neg(30);
    btn_raw = 8'h00;
    push(t + 36, 8'h00, 8'h00, 8'h10, 8'h00);
    wait_neg(12);

    // Up held with repeat disabled: press only.
    repeat_en = 1'b0;
    t = cyc; btn_raw = 8'h40;
    push(t + 6, 8'h40, 8'h40, 8'h00, 8'h40);
    wait_neg(30);
    btn_raw = 8'h00;
    push(t + 36, 8'h00, 8'h00, 8'h40, 8'h00);
    wait_neg(12);

    // Select held with repeat enabled: never repeats.
    repeat_en = 1'b1;
    t = cyc; btn_raw = 8'h04;
    push(t + 6, 8'h04, 8'h04, 8'h00, 8'h04);
    wait_neg(30);
    btn_raw = 8'h00;
    push(t + 36, 8'h00, 8'h00, 8'h04, 8'h00);
    wait_neg(12);

    // All buttons at once.
    repeat_en = 1'b0;
    t = cyc; btn_raw = 8'hFF;
    push(t + 6, 8'hFF, 8'hFF, 8'h00, 8'hFF);
    wait_neg(10);
    t = cyc; btn_raw = 8'h00;
    push(t + 6, 8'h00, 8'h00, 8'hFF, 8'h00);
    wait_neg(12);

    // Down held; reset mid-debounce, then reset mid-repeat.
    repeat_en = 1'b1;
    btn_raw = 8'h80;
    wait_neg(3);
    rst = 1'b1;
    wait_neg(1);
    check_quiet("rst_debounce_a", 8'h00);
    wait_neg(2);
    check_quiet("rst_debounce_b", 8'h00);
    rst = 1'b0;
    r = cyc;
    push(r + 6,  8'h80, 8'h80, 8'h00, 8'h80);
    push(r + 17, 8'h80, 8'h00, 8'h00, 8'h80);
    push(r + 20, 8'h80, 8'h00, 8'h00, 8'h80);
    wait_neg(21);
    rst = 1'b1;
    wait_neg(1);
    check_quiet("rst_repeat_a", 8'h00);
    wait_neg(2);
    check_quiet("rst_repeat_b", 8'h00);
    rst = 1'b0;
    r2 = cyc;
    push(r2 + 6, 8'h80, 8'h80, 8'h00, 8'h80);
    for (int k = 0; k < 3; k++) push(r2 + 17 + 3 * k, 8'h80, 8'h00, 8'h00, 8'h80);
    wait_neg(18);
    btn_raw = 8'h00;
    push(r2 + 24, 8'h00, 8'h00, 8'h80, 8'h00);
    wait_neg(12);
    check_quiet("final_idle", 8'h00);

    // Every expected pulse must have been seen.
    while (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      tests++;
      fails++;
      $display("FAIL missing_pulse: expected cyc=%0d lvl=%h prs=%h rel=%h evt=%h never observed",
               e.cyc, e.lvl, e.prs, e.rel, e.evt);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
